// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Holds the memory-wait FSM encoding, forwarding select codes and the PC register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } memst_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] REG_PC = 4'd15;

  // R15 is never a forwarding or load-use source; the PC path handles it.
  function automatic logic reg_hit(input logic [3:0] src, input logic [3:0] dst,
                                   input logic wr);
    return wr && (src == dst) && (dst != REG_PC);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage operand.
// The M-stage result is newer than W, so it takes priority.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] ra,
  input  logic [3:0] wa_m,
  input  logic [3:0] wa_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_hit(ra, wa_m, reg_write_m)) begin
      fwd = FWD_M;
    end else if (reg_hit(ra, wa_w, reg_write_w)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: operand forwarding, load-use and PC-write stalls,
// data-memory wait freeze with sticky timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WC_W-1:0] WC_ONE  = {{(WC_W-1){1'b0}}, 1'b1};
  localparam logic [WC_W-1:0] WC_LIM  = WC_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  memst_t            state_reg, state_next;
  logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
  logic              mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic [3:0]        ra_e [2];
  logic [1:0]        fwd_sel [2];

  logic              ldr_stall;
  logic              pc_wr_pend;
  logic              mem_stall;

  assign ra_e[0] = RA1E;
  assign ra_e[1] = RA2E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      hazard_fwd_unit u_fwd (
        .ra          (ra_e[gi]),
        .wa_m        (WA3M),
        .wa_w        (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_sel[gi])
      );
    end
  endgenerate

  assign ldr_stall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E)) && (WA3E != REG_PC);
  assign pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;

  // WAIT releases in the same cycle ready is seen, so ready masks the freeze there.
  assign mem_stall = ((state_reg == IDLE) && dmem_req && !dmem_ready) ||
                     ((state_reg == WAIT) && !dmem_ready) ||
                     (state_reg == ERR);

  assign wait_cnt_inc = wait_cnt_reg + WC_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
      if (StallF && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    case (state_reg)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_next    = WAIT;
          wait_cnt_next = WC_ONE;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_inc;
          if (wait_cnt_inc >= WC_LIM) begin
            state_next   = ERR;
            mem_err_next = 1'b1;
          end
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // While frozen, redirects are deferred: the stage registers hold PCSrc*/BranchTakenE.
  always_comb begin
    ForwardAE = fwd_sel[0];
    ForwardBE = fwd_sel[1];
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall || pc_wr_pend;
      StallD = ldr_stall;
      FlushD = pc_wr_pend || PCSrcW || BranchTakenE;
      FlushE = ldr_stall || BranchTakenE;
    end
  end

  assign mem_err      = mem_err_reg;
  assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: each vector pushes its expected
// outputs; a negedge monitor pops and compares one entry per cycle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       reset;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwm, rww, m2r, pcd, pce, pcm, pcw, bte, req, rdy;
  } in_t;

  typedef struct {
    int         id;
    logic [3:0] stl;
    logic [2:0] fl;
    logic [1:0] fa, fb;
    logic       err;
    logic       cnt_care;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t iv;
  in_t nv;
  exp_t exp_q[$];
  int vec_id = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [3:0] stall_cycles;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(iv.reset),
    .RA1D(iv.ra1d), .RA2D(iv.ra2d), .RA1E(iv.ra1e), .RA2E(iv.ra2e),
    .WA3E(iv.wa3e), .WA3M(iv.wa3m), .WA3W(iv.wa3w),
    .RegWriteM(iv.rwm), .RegWriteW(iv.rww), .MemtoRegE(iv.m2r),
    .PCSrcD(iv.pcd), .PCSrcE(iv.pce), .PCSrcM(iv.pcm), .PCSrcW(iv.pcw),
    .BranchTakenE(iv.bte), .dmem_req(iv.req), .dmem_ready(iv.rdy),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // stl = {F,D,E,M}, fl = {D,E,W}; cnt < 0 means the counter is not checked.
  function automatic exp_t ex(input logic [3:0] stl, input logic [2:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic err, input int cnt);
    exp_t e;
    e.id = 0;
    e.stl = stl;
    e.fl = fl;
    e.fa = fa;
    e.fb = fb;
    e.err = err;
    e.cnt_care = (cnt >= 0);
    e.cnt = (cnt >= 0) ? 4'(cnt) : 4'd0;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_t t;
    @(posedge clk);
    #1;
    iv = nv;
    t = e;
    t.id = vec_id;
    vec_id++;
    exp_q.push_back(t);
  endtask

  task automatic clr();
    nv = '0;
  endtask

  initial begin : monitor
    exp_t e;
    logic [3:0] a_stl;
    logic [2:0] a_fl;
    logic bad;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_stl = {StallF, StallD, StallE, StallM};
        a_fl = {FlushD, FlushE, FlushW};
        bad = (a_stl !== e.stl) || (a_fl !== e.fl) || (ForwardAE !== e.fa) ||
              (ForwardBE !== e.fb) || (mem_err !== e.err) ||
              (e.cnt_care && (stall_cycles !== e.cnt));
        vectors++;
        if (bad) begin
          miscompares++;
          $display("FAIL vec%0d: got stall=%b flush=%b fwdA=%b fwdB=%b err=%b cnt=%0d, want stall=%b flush=%b fwdA=%b fwdB=%b err=%b cnt=%0d(care=%b)",
                   e.id, a_stl, a_fl, ForwardAE, ForwardBE, mem_err, stall_cycles,
                   e.stl, e.fl, e.fa, e.fb, e.err, e.cnt, e.cnt_care);
        end else begin
          $display("vec%0d ok: stall=%b flush=%b fwdA=%b fwdB=%b err=%b cnt=%0d",
                   e.id, a_stl, a_fl, ForwardAE, ForwardBE, mem_err, stall_cycles);
        end
      end
    end
  end

  initial begin : driver
    iv = '0;
    iv.reset = 1'b1;
    // Reset overrides forwarding even with a matching M result.
    clr(); nv.reset = 1; nv.rwm = 1; nv.wa3m = 3; nv.ra1e = 3;
    step(ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, -1));
    clr(); nv.reset = 1;
    step(ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, 0));

    // Forwarding: M priority, W only, R15 excluded, mixed
    clr(); nv.rwm = 1; nv.wa3m = 3; nv.rww = 1; nv.wa3w = 3; nv.ra1e = 3; nv.ra2e = 3;
    step(ex(4'b0000, 3'b000, 2'b10, 2'b10, 1'b0, 0));
    clr(); nv.rww = 1; nv.wa3w = 3; nv.ra1e = 3; nv.ra2e = 7;
    step(ex(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 0));
    clr(); nv.rwm = 1; nv.wa3m = 15; nv.rww = 1; nv.wa3w = 15; nv.ra1e = 15; nv.ra2e = 15;
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 0));
    clr(); nv.rwm = 1; nv.wa3m = 2; nv.ra2e = 2; nv.rww = 1; nv.wa3w = 4; nv.ra1e = 4;
    step(ex(4'b0000, 3'b000, 2'b01, 2'b10, 1'b0, 0));

    // Load-use
    clr(); nv.m2r = 1; nv.wa3e = 5; nv.ra2d = 5; nv.ra1d = 1;
    step(ex(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 0));
    clr(); nv.m2r = 1; nv.wa3e = 15; nv.ra2d = 15; nv.ra1d = 1;
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1));
    clr(); nv.m2r = 0; nv.wa3e = 6; nv.ra1d = 6; nv.ra2d = 1;
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1));
    clr(); nv.reset = 1;
    step(ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, 1));

    // PC write walking D..W
    clr(); nv.pcd = 1;
    step(ex(4'b1000, 3'b100, 2'b00, 2'b00, 1'b0, 0));
    clr(); nv.pce = 1;
    step(ex(4'b1000, 3'b100, 2'b00, 2'b00, 1'b0, 1));
    clr(); nv.pcm = 1;
    step(ex(4'b1000, 3'b100, 2'b00, 2'b00, 1'b0, 2));
    clr(); nv.pcw = 1;
    step(ex(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0, 3));
    clr();
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 3));

    // Memory wait, ready on the 3rd cycle
    clr(); nv.req = 1;
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 3));
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 4));
    nv.rdy = 1;
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 5));
    // Zero-latency access in IDLE
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 5));
    clr();
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 5));

    // Branch redirect deferred by freeze
    clr(); nv.bte = 1; nv.req = 1;
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 5));
    nv.rdy = 1;
    step(ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 6));
    clr();
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 6));

    // Timeout with MEM_TIMEOUT=4, then sticky ERR ignoring ready, counter saturates
    clr(); nv.req = 1;
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 6));
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 7));
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 8));
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 9));
    nv.rdy = 1;
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 10));
    clr(); nv.rdy = 1;
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 11));
    for (int i = 0; i < 6; i++) begin
      step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, (12 + i > 15) ? 15 : 12 + i));
    end
    clr(); nv.reset = 1;
    step(ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b1, 15));
    clr();
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 0));

    // Reset in the middle of a wait drops the access
    clr(); nv.req = 1;
    step(ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 0));
    clr(); nv.reset = 1; nv.req = 1;
    step(ex(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, 1));
    clr();
    step(ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 0));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
